w5300_host_bus_ctrl: RTL and testbench

// Responder for the W5300 intraconnect (caddr/wr_data/rd_data/op_status) driven by the UDP conf/comm FSM.

---
 rtl/w5300_host_bus_ctrl_pkg.sv | 42 ++++
 rtl/w5300_host_bus_ctrl_if.sv | 17 +
 rtl/w5300_host_bus_ctrl_timer.sv | 32 +++
 rtl/w5300_host_bus_ctrl.sv | 136 +++++++++++++
 tb/tb_w5300_host_bus_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/w5300_host_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// w5300_host_bus_ctrl_pkg : shared field positions, timing and FSM encoding
// Rev 1.0
// ============================================================================
package w5300_host_bus_ctrl_pkg;

    localparam int CADDR_W = 12;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 16;

    localparam int CADDR_VALID_BIT = 11;
    localparam int CADDR_OP_BIT    = 10;

    localparam logic ADDR_S_VALID   = 1'b0;
    localparam logic ADDR_S_INVALID = 1'b1;
    localparam logic ADDR_OP_RD     = 1'b1;
    localparam logic ADDR_OP_WR     = 1'b0;

    localparam int RD_PULSE_NS = 70;
    localparam int WR_PULSE_NS = 50;

    typedef enum logic [3:0] {
        ST_RST_HOLD  = 4'd0,
        ST_PLL_WAIT  = 4'd1,
        ST_READY     = 4'd2,
        ST_IDLE      = 4'd3,
        ST_WR_SETUP  = 4'd4,
        ST_WR_STROBE = 4'd5,
        ST_WR_HOLD   = 4'd6,
        ST_RD_SETUP  = 4'd7,
        ST_RD_STROBE = 4'd8,
        ST_RECOVER   = 4'd9
    } state_t;

    // Round up so the strobe is never shorter than the chip minimum.
    function automatic int ns_to_cycles(input int ns, input int mhz);
        return (ns * mhz + 999) / 1000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/w5300_host_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
// w5300_host_bus_ctrl_if : requester-side request/response bundle
// Rev 1.0
// ============================================================================
interface w5300_host_bus_ctrl_if;
    import w5300_host_bus_ctrl_pkg::*;

    logic [CADDR_W-1:0] caddr;
    logic [DATA_W-1:0]  wr_data;
    logic [DATA_W-1:0]  rd_data;
    logic               op_status;

    modport master (output caddr, output wr_data, input rd_data, input op_status);
    modport slave  (input caddr, input wr_data, output rd_data, output op_status);
endinterface
`default_nettype wire

// File: rtl/w5300_host_bus_ctrl_timer.sv
`default_nettype none
// ============================================================================
// w5300_host_bus_ctrl_timer : loadable down-counter with zero flag
// Rev 1.0
// ============================================================================
module w5300_host_bus_ctrl_timer #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    output logic                  done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RESET_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule
`default_nettype wire

// File: rtl/w5300_host_bus_ctrl.sv
`default_nettype none
// ============================================================================
// w5300_host_bus_ctrl : W5300 power-up sequencer and direct-mode bus responder
// Rev 1.0
// ============================================================================
module w5300_host_bus_ctrl
    import w5300_host_bus_ctrl_pkg::*;
#(
    parameter int CLK_FREQ = 100,
    parameter int RST_US   = 2,
    parameter int PLL_US   = 10000,
    parameter int RD_PULSE = ns_to_cycles(RD_PULSE_NS, CLK_FREQ),
    parameter int WR_PULSE = ns_to_cycles(WR_PULSE_NS, CLK_FREQ),
    parameter int RECOVER  = 3
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    w5300_host_bus_ctrl_if.slave   host,
    output logic                   w_rst_n,
    output logic                   w_cs_n,
    output logic                   w_rd_n,
    output logic                   w_wr_n,
    output logic [ADDR_W-1:0]      w_addr,
    inout  wire  [DATA_W-1:0]      w_data
);

    localparam int RST_CYC  = RST_US * CLK_FREQ;
    localparam int PLL_CYC  = PLL_US * CLK_FREQ;
    localparam int MAX_A    = (RST_CYC > PLL_CYC) ? RST_CYC : PLL_CYC;
    localparam int MAX_B    = (RD_PULSE > WR_PULSE) ? RD_PULSE : WR_PULSE;
    localparam int MAX_C    = (MAX_B > RECOVER) ? MAX_B : RECOVER;
    localparam int MAX_LOAD = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int CNT_W    = ($clog2(MAX_LOAD) < 1) ? 1 : $clog2(MAX_LOAD);

    state_t             state;
    state_t             next_state;
    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_load_val;
    logic               tmr_done;
    logic               accept;
    logic               capture;
    logic               data_oe;
    logic [DATA_W-1:0]  data_q;

    w5300_host_bus_ctrl_timer #(
        .WIDTH     (CNT_W),
        .RESET_VAL (CNT_W'(RST_CYC - 1))
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RST_HOLD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_RST_HOLD:  if (tmr_done) next_state = ST_PLL_WAIT;
            ST_PLL_WAIT:  if (tmr_done) next_state = ST_READY;
            ST_READY:     next_state = ST_IDLE;
            ST_IDLE: begin
                if (host.caddr[CADDR_VALID_BIT] == ADDR_S_VALID) begin
                    next_state = (host.caddr[CADDR_OP_BIT] == ADDR_OP_RD) ? ST_RD_SETUP : ST_WR_SETUP;
                end
            end
            ST_WR_SETUP:  next_state = ST_WR_STROBE;
            ST_WR_STROBE: if (tmr_done) next_state = ST_WR_HOLD;
            ST_WR_HOLD:   next_state = ST_RECOVER;
            ST_RD_SETUP:  next_state = ST_RD_STROBE;
            ST_RD_STROBE: if (tmr_done) next_state = ST_RECOVER;
            ST_RECOVER:   if (tmr_done) next_state = ST_IDLE;
            default:      next_state = ST_RST_HOLD;
        endcase
    end

    // Every state entry reloads the single timer with that state's dwell minus one.
    always_comb begin
        tmr_load     = (next_state != state);
        tmr_load_val = '0;
        unique case (next_state)
            ST_RST_HOLD:  tmr_load_val = CNT_W'(RST_CYC - 1);
            ST_PLL_WAIT:  tmr_load_val = CNT_W'(PLL_CYC - 1);
            ST_WR_STROBE: tmr_load_val = CNT_W'(WR_PULSE - 1);
            ST_RD_STROBE: tmr_load_val = CNT_W'(RD_PULSE - 1);
            ST_RECOVER:   tmr_load_val = CNT_W'(RECOVER - 1);
            default:      tmr_load_val = '0;
        endcase
    end

    assign accept  = (state == ST_IDLE) && (next_state != ST_IDLE);
    assign capture = (state == ST_RD_STROBE) && tmr_done;

    // Pins are decoded from next_state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_rst_n        <= 1'b0;
            w_cs_n         <= 1'b1;
            w_rd_n         <= 1'b1;
            w_wr_n         <= 1'b1;
            w_addr         <= '0;
            data_q         <= '0;
            data_oe        <= 1'b0;
            host.rd_data   <= '0;
            host.op_status <= 1'b0;
        end else begin
            w_rst_n <= (next_state != ST_RST_HOLD);
            w_cs_n  <= !(next_state inside {ST_WR_SETUP, ST_WR_STROBE, ST_WR_HOLD,
                                            ST_RD_SETUP, ST_RD_STROBE});
            w_rd_n  <= (next_state != ST_RD_STROBE);
            w_wr_n  <= (next_state != ST_WR_STROBE);
            data_oe <= (next_state inside {ST_WR_SETUP, ST_WR_STROBE, ST_WR_HOLD});
            host.op_status <= (next_state == ST_READY) ||
                              ((next_state == ST_RECOVER) && (state != ST_RECOVER));
            if (accept) begin
                w_addr <= host.caddr[ADDR_W-1:0];
                data_q <= host.wr_data;
            end
            if (capture) begin
                host.rd_data <= w_data;
            end
        end
    end

    assign w_data = data_oe ? data_q : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_w5300_host_bus_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_w5300_host_bus_ctrl : bus-model bench with a memory-backed W5300 stand-in
// Rev 1.0
// ============================================================================
module tb_w5300_host_bus_ctrl;
    import w5300_host_bus_ctrl_pkg::*;

    localparam int CLK_FREQ = 100;
    localparam int RST_US   = 1;
    localparam int PLL_US   = 2;
    localparam int RST_CYC  = RST_US * CLK_FREQ;
    localparam int PLL_CYC  = PLL_US * CLK_FREQ;
    localparam int RD_P     = (70 * CLK_FREQ + 999) / 1000;
    localparam int WR_P     = (50 * CLK_FREQ + 999) / 1000;
    localparam int REC      = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    w5300_host_bus_ctrl_if bus_if ();

    logic        w_rst_n, w_cs_n, w_rd_n, w_wr_n;
    logic [9:0]  w_addr;
    wire  [15:0] w_data;

    w5300_host_bus_ctrl #(
        .CLK_FREQ (CLK_FREQ),
        .RST_US   (RST_US),
        .PLL_US   (PLL_US),
        .RECOVER  (REC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .host    (bus_if.slave),
        .w_rst_n (w_rst_n),
        .w_cs_n  (w_cs_n),
        .w_rd_n  (w_rd_n),
        .w_wr_n  (w_wr_n),
        .w_addr  (w_addr),
        .w_data  (w_data)
    );

    // Chip stand-in: drives memory onto DATA while RD is low, stores on WR release.
    logic [15:0] chip_mem [1024];
    logic [15:0] exp_mem  [1024];
    assign w_data = (!w_rd_n && w_rst_n) ? chip_mem[w_addr] : 16'hzzzz;
    always @(posedge w_wr_n) begin
        if (rst_n && w_rst_n) chip_mem[w_addr] <= w_data;
    end

    int pass_cnt  = 0;
    int check_cnt = 0;
    int idle_at   = 0;

    task automatic test_power_up(input string tag);
        int rst_low = 0, first_hi = 0, op_first = 0, op_cnt = 0, strobes = 0;
        @(negedge clk);
        rst_n = 1'b0;
        bus_if.caddr   = {ADDR_S_VALID, 1'($urandom), 10'($urandom)};
        bus_if.wr_data = 16'($urandom);
        repeat (2) @(negedge clk);
        check_cnt++;
        if ({w_rst_n, w_cs_n, w_rd_n, w_wr_n, bus_if.op_status, w_addr, bus_if.rd_data}
            !== {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 16'h0000}) begin
            $display("FAIL %s reset_values: got rst=%b cs=%b rd=%b wr=%b op=%b addr=%h rd_data=%h want 0 1 1 1 0 000 0000",
                     tag, w_rst_n, w_cs_n, w_rd_n, w_wr_n, bus_if.op_status, w_addr, bus_if.rd_data);
        end else pass_cnt++;
        rst_n = 1'b1;
        for (int n = 1; n <= RST_CYC + PLL_CYC + 30; n++) begin
            if (n > 1) @(negedge clk);
            if (!w_rst_n) rst_low++;
            else if (first_hi == 0) first_hi = n;
            if (bus_if.op_status) begin
                op_cnt++;
                if (op_first == 0) op_first = n;
            end
            if (!w_cs_n || !w_rd_n || !w_wr_n) strobes++;
            if (n < RST_CYC + PLL_CYC + 1) begin
                bus_if.caddr   = {ADDR_S_VALID, 1'($urandom), 10'($urandom)};
                bus_if.wr_data = 16'($urandom);
            end else begin
                bus_if.caddr = {ADDR_S_INVALID, 11'($urandom)};
            end
        end
        check_cnt++;
        if (rst_low !== RST_CYC) $display("FAIL %s rst_low_cycles: got %0d want %0d", tag, rst_low, RST_CYC);
        else pass_cnt++;
        check_cnt++;
        if (first_hi !== RST_CYC + 1) $display("FAIL %s rst_release_cycle: got %0d want %0d", tag, first_hi, RST_CYC + 1);
        else pass_cnt++;
        check_cnt++;
        if (op_first !== RST_CYC + PLL_CYC + 1) $display("FAIL %s ready_cycle: got %0d want %0d", tag, op_first, RST_CYC + PLL_CYC + 1);
        else pass_cnt++;
        check_cnt++;
        if (op_cnt !== 1) $display("FAIL %s ready_pulses: got %0d want 1", tag, op_cnt);
        else pass_cnt++;
        check_cnt++;
        if (strobes !== 0) $display("FAIL %s powerup_strobes: got %0d want 0", tag, strobes);
        else pass_cnt++;
        check_cnt++;
        if (w_addr !== 10'h000) $display("FAIL %s powerup_latch: got addr %h want 000", tag, w_addr);
        else pass_cnt++;
        idle_at = 0;
    endtask

    // One access; expected pin pattern comes from cycle offsets relative to acceptance.
    task automatic run_access(input bit is_rd, input logic [9:0] addr, input logic [15:0] data, input string tag);
        int c0, opk, k;
        logic [15:0] exp_rd;
        logic e_cs, e_rd, e_wr, e_op;
        @(negedge clk);
        c0 = (cyc >= idle_at) ? cyc : idle_at;
        bus_if.caddr   = {ADDR_S_VALID, (is_rd ? ADDR_OP_RD : ADDR_OP_WR), addr};
        bus_if.wr_data = data;
        opk = is_rd ? RD_P + 2 : WR_P + 3;
        exp_rd = exp_mem[addr];
        if (!is_rd) exp_mem[addr] = data;
        k = cyc - c0;
        while (k < opk) begin
            @(negedge clk);
            k = cyc - c0;
            e_cs = (k >= 1) && (is_rd ? (k <= RD_P + 1) : (k <= WR_P + 2));
            e_rd = is_rd  && (k >= 2) && (k <= RD_P + 1);
            e_wr = !is_rd && (k >= 2) && (k <= WR_P + 1);
            e_op = (k == opk);
            check_cnt++;
            if ({w_rst_n, w_cs_n, w_rd_n, w_wr_n, bus_if.op_status} !== {1'b1, !e_cs, !e_rd, !e_wr, e_op}) begin
                $display("FAIL %s pins c%0d: got rst=%b cs=%b rd=%b wr=%b op=%b want 1 %b %b %b %b",
                         tag, k, w_rst_n, w_cs_n, w_rd_n, w_wr_n, bus_if.op_status, !e_cs, !e_rd, !e_wr, e_op);
            end else pass_cnt++;
            if (e_cs) begin
                check_cnt++;
                if (w_addr !== addr) $display("FAIL %s addr c%0d: got %h want %h", tag, k, w_addr, addr);
                else pass_cnt++;
            end
            if (e_cs && !is_rd) begin
                check_cnt++;
                if (w_data !== data) $display("FAIL %s wdata c%0d: got %h want %h", tag, k, w_data, data);
                else pass_cnt++;
            end
        end
        if (is_rd) begin
            check_cnt++;
            if (bus_if.rd_data !== exp_rd) $display("FAIL %s rd_data: got %h want %h", tag, bus_if.rd_data, exp_rd);
            else pass_cnt++;
        end
        idle_at = c0 + opk + REC;
    endtask

    task automatic release_req();
        @(negedge clk);
        bus_if.caddr = {ADDR_S_INVALID, 11'($urandom)};
    endtask

    task automatic test_write_basic();
        run_access(1'b0, 10'h018, 16'hC0A8, "write_basic");
        release_req();
    endtask

    task automatic test_read_basic();
        run_access(1'b1, 10'h0FE, 16'h0000, "read_basic");
        release_req();
    endtask

    task automatic test_rd_hold();
        repeat (5) @(negedge clk);
        check_cnt++;
        if (bus_if.rd_data !== 16'h5300) $display("FAIL rd_hold_idle: got %h want 5300", bus_if.rd_data);
        else pass_cnt++;
        run_access(1'b0, 10'h0FE, 16'h1234, "rd_hold_write");
        release_req();
        check_cnt++;
        if (bus_if.rd_data !== 16'h5300) $display("FAIL rd_hold_after_write: got %h want 5300", bus_if.rd_data);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            run_access(1'($urandom), 10'($urandom_range(0, 31)), 16'($urandom), "back_to_back");
        end
        run_access(1'b1, 10'h0FE, 16'h0000, "back_to_back_fe");
        release_req();
    endtask

    task automatic test_idle_invalid();
        logic [13:0] prev;
        int toggles = 0, ops = 0;
        @(negedge clk);
        prev = {w_rst_n, w_cs_n, w_rd_n, w_wr_n, w_addr};
        for (int i = 0; i < 1000; i++) begin
            bus_if.caddr   = {ADDR_S_INVALID, 11'($urandom)};
            bus_if.wr_data = 16'($urandom);
            @(negedge clk);
            if ({w_rst_n, w_cs_n, w_rd_n, w_wr_n, w_addr} !== prev) toggles++;
            prev = {w_rst_n, w_cs_n, w_rd_n, w_wr_n, w_addr};
            if (bus_if.op_status) ops++;
        end
        check_cnt++;
        if (toggles !== 0) $display("FAIL idle_pin_toggles: got %0d want 0", toggles);
        else pass_cnt++;
        check_cnt++;
        if (ops !== 0) $display("FAIL idle_op_status: got %0d want 0", ops);
        else pass_cnt++;
        check_cnt++;
        if ({w_cs_n, w_rd_n, w_wr_n} !== 3'b111) $display("FAIL idle_strobes: got %b want 111", {w_cs_n, w_rd_n, w_wr_n});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_strobe();
        int c0, k;
        @(negedge clk);
        c0 = (cyc >= idle_at) ? cyc : idle_at;
        bus_if.caddr   = {ADDR_S_VALID, ADDR_OP_WR, 10'h155};
        bus_if.wr_data = 16'($urandom);
        k = cyc - c0;
        while (k < 3) begin
            @(negedge clk);
            k = cyc - c0;
        end
        check_cnt++;
        if ({w_cs_n, w_wr_n} !== 2'b00) $display("FAIL mid_strobe_entry: got cs=%b wr=%b want 0 0", w_cs_n, w_wr_n);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        check_cnt++;
        if ({w_rst_n, w_cs_n, w_rd_n, w_wr_n, bus_if.op_status} !== 5'b0_111_0)
            $display("FAIL mid_strobe_reset: got rst=%b cs=%b rd=%b wr=%b op=%b want 0 1 1 1 0",
                     w_rst_n, w_cs_n, w_rd_n, w_wr_n, bus_if.op_status);
        else pass_cnt++;
        bus_if.caddr = {ADDR_S_INVALID, 11'h000};
        test_power_up("repower");
        run_access(1'b1, 10'h0FE, 16'h0000, "after_repower");
        release_req();
    endtask

    initial begin
        logic [15:0] v;
        bus_if.caddr   = {ADDR_S_INVALID, 11'h000};
        bus_if.wr_data = 16'h0000;
        for (int i = 0; i < 1024; i++) begin
            v = 16'($urandom);
            chip_mem[i] <= v;
            exp_mem[i]   = v;
        end
        chip_mem[10'h0FE] <= 16'h5300;
        exp_mem[10'h0FE]   = 16'h5300;

        test_power_up("power_up");
        test_write_basic();
        test_read_basic();
        test_rd_hold();
        test_back_to_back();
        test_idle_invalid();
        test_reset_mid_strobe();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
`default_nettype wire
